// File: rtl/sqrt_sequencer_if.sv
// Handshake and core-side signal bundle for sqrt_sequencer.
// slave = the sequencer; master = operand source, result consumer and sqrt core.
interface sqrt_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] core_a;
   logic        core_start;
   logic [31:0] core_out;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_special;
   logic        out_timeout;

   modport slave (
      input  in_valid, in_a, core_out, out_ready,
      output in_ready, core_a, core_start, out_valid, out_result, out_special, out_timeout
   );

   modport master (
      output in_valid, in_a, core_out, out_ready,
      input  in_ready, core_a, core_start, out_valid, out_result, out_special, out_timeout
   );
endinterface

// File: rtl/sqrt_sequencer.sv
// Control stage around the Newton square-root core: special-operand bypass, iteration
// count and result port. Define SQRT_SEQ_CONV_EN to enable early exit on convergence.
module sqrt_sequencer #(
   parameter int MAX_ITER = 16
) (
   input logic             sqrt_clk,
   input logic             reset,
   sqrt_sequencer_if.slave bus
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;

   typedef enum logic [1:0] {IDLE, START, ITER, DONE} state_t;

   state_t      r_state;
   logic [31:0] r_core_a;
   logic        r_core_start;
   logic        r_in_ready;
   logic        r_out_valid;
   logic [31:0] r_result;
   logic        r_special;
   logic        r_timeout;
   logic [7:0]  r_iter_cnt;

   logic [7:0]  w_exp;
   logic [22:0] w_man;
   logic        w_special;
   logic [31:0] w_special_val;
   logic        w_at_max;
   logic        w_exit;
   logic        w_tmo;

   assign w_exp = bus.in_a[30:23];
   assign w_man = bus.in_a[22:0];

   always_comb begin
      w_special     = 1'b1;
      w_special_val = QNAN;
      if (w_exp == 8'hFF && w_man != 23'd0)
         w_special_val = QNAN;
      else if (w_exp == 8'h00)
         w_special_val = {bus.in_a[31], 31'b0};
      else if (bus.in_a == PINF)
         w_special_val = PINF;
      else if (bus.in_a[31])
         w_special_val = QNAN;
      else
         w_special = 1'b0;
   end

   // r_iter_cnt counts completed ITER cycles, so this cycle is number MAX_ITER
   assign w_at_max = (r_iter_cnt == 8'(MAX_ITER - 1));

`ifdef SQRT_SEQ_CONV_EN
   logic [31:0] r_prev;
   logic        w_conv;
   assign w_conv = (bus.core_out == r_prev) && (r_iter_cnt >= 8'd2);
   assign w_exit = w_conv || w_at_max;
   assign w_tmo  = !w_conv;

   always_ff @(posedge sqrt_clk or posedge reset) begin
      if (reset)
         r_prev <= 32'd0;
      else if (r_state == ITER)
         r_prev <= bus.core_out;
   end
`else
   assign w_exit = w_at_max;
   assign w_tmo  = 1'b0;
`endif

   always_ff @(posedge sqrt_clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_core_a     <= 32'd0;
         r_core_start <= 1'b0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_result     <= 32'd0;
         r_special    <= 1'b0;
         r_timeout    <= 1'b0;
         r_iter_cnt   <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_core_a   <= bus.in_a;
                  r_in_ready <= 1'b0;
                  if (w_special) begin
                     r_result    <= w_special_val;
                     r_special   <= 1'b1;
                     r_timeout   <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_core_start <= 1'b1;
                     r_state      <= START;
                  end
               end
            end
            START: begin
               r_core_start <= 1'b0;
               r_iter_cnt   <= 8'd0;
               r_state      <= ITER;
            end
            ITER: begin
               r_iter_cnt <= r_iter_cnt + 8'd1;
               if (w_exit) begin
                  r_result    <= bus.core_out;
                  r_special   <= 1'b0;
                  r_timeout   <= w_tmo;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.core_a      = r_core_a;
   assign bus.core_start  = r_core_start;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_result  = r_result;
   assign bus.out_special = r_special;
   assign bus.out_timeout = r_timeout;
endmodule

// File: tb/tb_sqrt_sequencer.sv
// Self-checking bench for sqrt_sequencer: vector table, corner sequences and random
// operands against a sample-list reference model. Honours SQRT_SEQ_CONV_EN.
module tb_sqrt_sequencer;
   localparam int MAX = 4;

   logic sqrt_clk = 1'b0;
   logic reset;

   sqrt_sequencer_if bus();

   sqrt_sequencer #(.MAX_ITER(MAX)) dut (
      .sqrt_clk (sqrt_clk),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 sqrt_clk = ~sqrt_clk;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   // Core stand-in: estimate sequence indexed by cycles since the reseed edge.
   // "never-repeat" mode yields a strictly increasing sequence.
   function automatic logic [31:0] sample(input logic nr, input logic [31:0] tgt,
                                          input int len, input int idx);
      logic [7:0] i8;
      i8 = 8'(idx);
      if (nr) return 32'h1000_0000 + 32'(idx);
      if (idx < len) return tgt ^ {8'h5A, 16'h0000, i8};
      return tgt;
   endfunction

   logic        core_nr;
   logic [31:0] core_tgt;
   int          core_len;
   int          core_step;
   int          start_cnt;

   initial begin
      core_step = 0;
      start_cnt = 0;
   end

   always @(posedge sqrt_clk) begin
      if (bus.core_start) begin
         core_step <= 0;
         start_cnt <= start_cnt + 1;
      end else if (core_step < 1000) begin
         core_step <= core_step + 1;
      end
   end

   assign bus.core_out = sample(core_nr, core_tgt, core_len, core_step);

   // Reference: the k-th ITER cycle (1-based) sees sample k-1.
   function automatic void model(input logic nr, input logic [31:0] tgt, input int len,
                                 output logic [31:0] res, output logic to, output int n);
      logic [31:0] s[$];
      bit          found;
      for (int k = 1; k <= MAX; k++) s.push_back(sample(nr, tgt, len, k - 1));
      n     = MAX;
      res   = s[MAX-1];
      to    = 1'b0;
      found = 1'b0;
`ifdef SQRT_SEQ_CONV_EN
      for (int k = 3; k <= MAX; k++) begin
         if (!found && s[k-1] == s[k-2]) begin
            found = 1'b1;
            n     = k;
            res   = s[k-1];
         end
      end
      to = !found;
`endif
   endfunction

   task automatic start_op(input logic [31:0] a, input logic nr, input logic [31:0] tgt,
                           input int len);
      int t;
      core_nr  = nr;
      core_tgt = tgt;
      core_len = len;
      t = 0;
      @(negedge sqrt_clk);
      while (!bus.in_ready && t < 100) begin
         @(negedge sqrt_clk);
         t++;
      end
      chk1("accept_ready", bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      @(posedge sqrt_clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_a     = $urandom;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 60) begin
         @(posedge sqrt_clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain(input int hold);
      repeat (hold) @(posedge sqrt_clk);
      @(negedge sqrt_clk);
      bus.out_ready = 1'b1;
      @(posedge sqrt_clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] tgt;
      int          len;
      logic [31:0] exp;
      logic        sp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] m_res;
      logic        m_to;
      int          m_n;
      int          lat;
      int          s0;
      int          hv, hs, hr;

      tbl[0]  = '{32'h4080_0000, 32'h4000_0000, 1, 32'h4000_0000, 1'b0};
      tbl[1]  = '{32'hC080_0000, 32'h0,         0, 32'h7FC0_0000, 1'b1};
      tbl[2]  = '{32'h8000_0000, 32'h0,         0, 32'h8000_0000, 1'b1};
      tbl[3]  = '{32'h7F80_0000, 32'h0,         0, 32'h7F80_0000, 1'b1};
      tbl[4]  = '{32'h7F80_0001, 32'h0,         0, 32'h7FC0_0000, 1'b1};
      tbl[5]  = '{32'hFFC0_0000, 32'h0,         0, 32'h7FC0_0000, 1'b1};
      tbl[6]  = '{32'h0000_0000, 32'h0,         0, 32'h0000_0000, 1'b1};
      tbl[7]  = '{32'h0040_0000, 32'h0,         0, 32'h0000_0000, 1'b1};
      tbl[8]  = '{32'h8040_0000, 32'h0,         0, 32'h8000_0000, 1'b1};
      tbl[9]  = '{32'hFF80_0000, 32'h0,         0, 32'h7FC0_0000, 1'b1};
      tbl[10] = '{32'h4110_0000, 32'h4040_0000, 0, 32'h4040_0000, 1'b0};
      tbl[11] = '{32'h3E80_0000, 32'h3F00_0000, 1, 32'h3F00_0000, 1'b0};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = 32'h0;
      bus.out_ready = 1'b0;
      core_nr = 1'b0; core_tgt = 32'h0; core_len = 0;
      repeat (3) @(posedge sqrt_clk);
      #1;
      chk1("rst_in_ready", bus.in_ready, 1'b1);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_core_start", bus.core_start, 1'b0);
      chk("rst_out_result", bus.out_result, 32'h0);
      chk("rst_core_a", bus.core_a, 32'h0);
      @(negedge sqrt_clk);
      reset = 1'b0;

      // in_valid never asserted: nothing happens
      repeat (3) @(posedge sqrt_clk);
      #1;
      chk1("idle_no_valid", bus.out_valid, 1'b0);

      for (int i = 0; i < 12; i++) begin
         s0 = start_cnt;
         start_op(tbl[i].a, 1'b0, tbl[i].tgt, tbl[i].len);
         wait_valid(lat);
         model(1'b0, tbl[i].tgt, tbl[i].len, m_res, m_to, m_n);
         chk($sformatf("tbl%0d_result", i), bus.out_result, tbl[i].exp);
         chk1($sformatf("tbl%0d_special", i), bus.out_special, tbl[i].sp);
         chk1($sformatf("tbl%0d_timeout", i), bus.out_timeout, 1'b0);
         chk($sformatf("tbl%0d_core_a", i), bus.core_a, tbl[i].a);
         chk($sformatf("tbl%0d_starts", i), 32'(start_cnt - s0), tbl[i].sp ? 32'd0 : 32'd1);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), tbl[i].sp ? 32'd1 : 32'(m_n + 2));
         drain(0);
      end

      // never-repeating core: runs the full MAX iterations
      s0 = start_cnt;
      start_op(32'h4080_0000, 1'b1, 32'h0, 0);
      wait_valid(lat);
      model(1'b1, 32'h0, 0, m_res, m_to, m_n);
      chk("nr_result", bus.out_result, 32'h1000_0003);
      chk("nr_latency", 32'(lat), 32'(MAX + 2));
`ifdef SQRT_SEQ_CONV_EN
      chk1("nr_timeout", bus.out_timeout, 1'b1);
`else
      chk1("nr_timeout", bus.out_timeout, 1'b0);
`endif
      chk1("nr_model_timeout", bus.out_timeout, m_to);
      chk("nr_starts", 32'(start_cnt - s0), 32'd1);
      drain(0);

      // back-pressure
      start_op(32'h4110_0000, 1'b0, 32'h4040_0000, 1);
      wait_valid(lat);
      hv = 0; hs = 0; hr = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge sqrt_clk);
         #1;
         if (bus.out_valid) hv++;
         if (bus.out_result == 32'h4040_0000 && !bus.out_special) hs++;
         if (!bus.in_ready) hr++;
      end
      chk("bp_valid_held", 32'(hv), 32'd10);
      chk("bp_result_held", 32'(hs), 32'd10);
      chk("bp_in_ready_low", 32'(hr), 32'd10);
      @(negedge sqrt_clk);
      bus.out_ready = 1'b1;
      chk1("bp_in_ready_before", bus.in_ready, 1'b0);
      @(posedge sqrt_clk);
      #1;
      bus.out_ready = 1'b0;
      chk1("bp_in_ready_after", bus.in_ready, 1'b1);
      chk1("bp_valid_after", bus.out_valid, 1'b0);

      // in_valid pulsed while busy
      start_op(32'h4110_0000, 1'b1, 32'h0, 0);
      @(negedge sqrt_clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h3F80_0000;
      @(posedge sqrt_clk);
      #1;
      bus.in_valid = 1'b0;
      chk("busy_core_a", bus.core_a, 32'h4110_0000);
      chk1("busy_in_ready", bus.in_ready, 1'b0);
      wait_valid(lat);
      chk("busy_result", bus.out_result, 32'h1000_0003);
      chk("busy_core_a_end", bus.core_a, 32'h4110_0000);
      drain(2);

      // reset during the third ITER cycle
      s0 = start_cnt;
      start_op(32'h4080_0000, 1'b1, 32'h0, 0);
      repeat (3) @(posedge sqrt_clk);
      #1;
      reset = 1'b1;
      #1;
      chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
      chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
      chk1("mid_rst_core_start", bus.core_start, 1'b0);
      chk("mid_rst_result", bus.out_result, 32'h0);
      chk("mid_rst_core_a", bus.core_a, 32'h0);
      chk1("mid_rst_special", bus.out_special, 1'b0);
      chk1("mid_rst_timeout", bus.out_timeout, 1'b0);
      repeat (2) @(posedge sqrt_clk);
      @(negedge sqrt_clk);
      reset = 1'b0;
      repeat (2) @(posedge sqrt_clk);
      #1;
      chk1("post_rst_no_valid", bus.out_valid, 1'b0);
      chk("post_rst_starts", 32'(start_cnt - s0), 32'd1);
      start_op(32'h3E80_0000, 1'b0, 32'h3F00_0000, 1);
      wait_valid(lat);
      chk("post_rst_result", bus.out_result, 32'h3F00_0000);
      chk1("post_rst_special", bus.out_special, 1'b0);
      drain(0);

      // random positive normal operands
      for (int r = 0; r < 40; r++) begin
         logic [31:0] a, tgt;
         int          len;
         a   = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
         tgt = $urandom;
         len = $urandom_range(5, 0);
         s0  = start_cnt;
         start_op(a, 1'b0, tgt, len);
         wait_valid(lat);
         model(1'b0, tgt, len, m_res, m_to, m_n);
         chk($sformatf("rnd%0d_result", r), bus.out_result, m_res);
         chk1($sformatf("rnd%0d_timeout", r), bus.out_timeout, m_to);
         chk1($sformatf("rnd%0d_special", r), bus.out_special, 1'b0);
         chk($sformatf("rnd%0d_latency", r), 32'(lat), 32'(m_n + 2));
         chk($sformatf("rnd%0d_starts", r), 32'(start_cnt - s0), 32'd1);
         drain($urandom_range(3, 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sqrt_sequencer.md
# sqrt_sequencer

Control stage wrapped around the Newton-iteration square-root core. Accepts an IEEE-754 single-precision operand over a valid/ready handshake and screens out special operands without using the core. For ordinary operands it pulses the core's start, counts iterations and detects convergence. It then presents the final estimate on a valid/ready output port. It runs on the same clock as the core's estimate register.

## Interface
- MAX_ITER, 16: maximum Newton iterations per operand (2..255).
- sqrt_clk  in  1  clock; same edge that updates the core estimate.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operand present.
- in_ready  out  1  sequencer can accept an operand.
- in_a  in  32  operand, IEEE-754 single.
- core_a  out  32  operand held for the core for the whole operation.
- core_start  out  1  one-cycle pulse; the core reseeds its estimate on that edge.
- core_out  in  32  current core estimate.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  square root, IEEE-754 single.
- out_special  out  1  result came from special-case bypass.
- out_timeout  out  1  MAX_ITER reached without convergence.

## Operation
- States:
  - IDLE: in_ready=1. The handshake in_valid&in_ready latches in_a into core_a.
    - Special operand: go to DONE.
    - Otherwise: go to START.
  - START: core_start=1 for exactly one cycle. Clear iter_cnt. Go to ITER.
  - ITER: each cycle, prev<=core_out and iter_cnt<=iter_cnt+1.
    - Go to DONE when converged or when iter_cnt==MAX_ITER.
    - On the transition, result<=core_out.
  - DONE: out_valid=1 and outputs stable. Go to IDLE on out_valid&out_ready.
- Special cases, checked at acceptance in this priority order:
  - exp==0xFF with mantissa!=0 (NaN) -> 0x7FC00000.
  - ±0, or exp==0 (denormal, flushed to zero) -> result {sign,31'b0}.
  - +inf (0x7F800000) -> 0x7F800000.
  - Sign=1 with nonzero magnitude -> 0x7FC00000.
  - All of the above set out_special=1 and out_timeout=0.
- Convergence: core_out==prev with iter_cnt>=2, a bit-exact compare.
- out_timeout=1 only when the exit was caused by iter_cnt==MAX_ITER and the compare was false in that same cycle.
- iter_cnt is 8 bits and never wraps, because the exit fires at MAX_ITER.
- core_a holds the latched operand from acceptance until the next acceptance; it never tracks in_a.

## Timing
- Reset values:
  - State IDLE; in_ready=1.
  - core_start=0; out_valid=0.
  - out_result=0, core_a=0, out_special=0, out_timeout=0.
  - prev=0, iter_cnt=0.
- Reset asserted mid-operation returns to IDLE immediately. Any in-flight result is discarded and core_start is not asserted.
- Special-case latency: out_valid rises on the edge after acceptance (1 cycle).
- Normal latency: acceptance, then 1 cycle START, then N cycles ITER, then out_valid. N = cycles to convergence or MAX_ITER.
- The first core_out sample after the START edge is the seed.
- Back-to-back operands:
  - in_ready is low from acceptance until the DONE handshake completes.
  - in_ready rises the cycle after out_valid&out_ready.
  - There is no same-cycle accept-on-drain.
- out_valid, once high, stays high with stable out_result/out_special/out_timeout until out_ready. There is no combinational path from out_ready to out_valid.
- in_valid deasserted before acceptance is ignored; no state change.

## Configuration
- SQRT_SEQ_CONV_EN defined:
  - Early exit on convergence as described above.
  - out_timeout is meaningful.
- SQRT_SEQ_CONV_EN undefined:
  - No compare logic and no prev register.
  - ITER always runs exactly MAX_ITER cycles.
  - out_timeout is tied to 0.

## Test plan
- in_a=0x40800000 (4.0) -> one core_start pulse, then out_result=0x40000000 (2.0). out_special=0 and out_timeout=0. With SQRT_SEQ_CONV_EN, exit occurs before MAX_ITER.
- in_a=0xC0800000 (-4.0) -> no core_start pulse. out_valid on the next edge with out_result=0x7FC00000 and out_special=1. in_a=0x80000000 -> 0x80000000. in_a=0x7F800000 -> 0x7F800000.
- Core model that never repeats its estimate, with MAX_ITER=4 -> exactly 4 ITER cycles, out_timeout=1, out_result equal to the 4th sample.
- Back-pressure: in_a=0x41100000 (9.0) with out_ready=0 for 10 cycles -> out_valid held high and out_result=0x40400000 held stable; in_ready=0 throughout. in_ready rises one cycle after out_ready=1.
- Reset at cycle 3 of ITER, then release -> all outputs at reset values and state IDLE. A new operand 0x3E800000 (0.25) gives out_result=0x3F000000.
- in_valid pulsed while the sequencer is busy -> no acceptance, and core_a is unchanged.
